// File: rtl/ar_multicycle_sequencer.sv
// Multi-cycle sequencer for the AR-type datapath: fetch over req/ack, hold the
// instruction register, then step through decode, execute and writeback.
module ar_multicycle_sequencer #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16,
  parameter logic [4:0]      OP_AR    = 5'b00000,
  parameter logic [4:0]      OP_HALT  = 5'b11111
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             run,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [PC_W-1:0]  pc,
  output logic             reg_write,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    HALT      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             pending_q, pending_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      pending_q <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pending_q <= pending_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pending_d = pending_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    // Once raised, the request is held by pending even if run drops.
    imem_req  = (state_q == FETCH) && (run || pending_q);
    reg_write = (state_q == WRITEBACK);

    unique case (state_q)
      FETCH: begin
        if (imem_req) begin
          if (imem_ack) begin
            instr_d   = imem_rdata;
            pc_d      = pc_q + PC_W'(1);
            pending_d = 1'b0;
            state_d   = DECODE;
          end else begin
            pending_d = 1'b1;
          end
        end
      end
      DECODE: begin
        if (instr_q[31:27] == OP_AR) begin
          state_d = EXECUTE;
        end else if (instr_q[31:27] == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end else begin
          illegal_d = 1'b1;
          state_d   = FETCH;
        end
      end
      EXECUTE:   state_d = WRITEBACK;
      WRITEBACK: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = FETCH;
      end
      HALT:      state_d = HALT;
      default:   state_d = FETCH;
    endcase
  end

  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign pc        = pc_q;
  assign state     = state_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_ar_multicycle_sequencer.sv
// Directed bench for ar_multicycle_sequencer with a 4-bit PC so the wrap case
// is reachable; expected values are hand-computed per cycle.
module tb_ar_multicycle_sequencer;

  localparam int unsigned PC_W  = 4;
  localparam int unsigned CNT_W = 16;

  logic             CLK;
  logic             RESET;
  logic             run;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic [31:0]      instr;
  logic [PC_W-1:0]  pc;
  logic             reg_write;
  logic [2:0]       state;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned pulses;

  ar_multicycle_sequencer #(
    .PC_W    (PC_W),
    .RESET_PC(4'd0),
    .CNT_W   (CNT_W),
    .OP_AR   (5'b00000),
    .OP_HALT (5'b11111)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .run       (run),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .instr     (instr),
    .pc        (pc),
    .reg_write (reg_write),
    .state     (state),
    .halted    (halted),
    .illegal   (illegal),
    .retired   (retired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then settled 1 time unit after posedge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    step();
    step();
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    #2;

    // 1: zero-wait AR fetch, timing of reg_write and next request
    do_reset();
    settle();
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_regwr", 32'(reg_write), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_req_norun", 32'(imem_req), 32'd0);
    run = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0000_0800;
    settle();
    check("c1_req", 32'(imem_req), 32'd1);
    check("c1_addr", 32'(imem_addr), 32'd0);
    step();
    imem_ack = 1'b0;
    settle();
    check("c2_state", 32'(state), 32'd1);
    check("c2_instr", instr, 32'h0000_0800);
    check("c2_pc", 32'(pc), 32'd1);
    check("c2_req", 32'(imem_req), 32'd0);
    check("c2_regwr", 32'(reg_write), 32'd0);
    step();
    check("c3_state", 32'(state), 32'd2);
    check("c3_regwr", 32'(reg_write), 32'd0);
    step();
    check("c4_state", 32'(state), 32'd3);
    check("c4_regwr", 32'(reg_write), 32'd1);
    check("c4_instr", instr, 32'h0000_0800);
    step();
    check("c5_state", 32'(state), 32'd0);
    check("c5_regwr", 32'(reg_write), 32'd0);
    check("c5_retired", 32'(retired), 32'd1);
    check("c5_req", 32'(imem_req), 32'd1);
    check("c5_addr", 32'(imem_addr), 32'd1);

    // 2: late ack with run dropped after the first request cycle
    do_reset();
    run = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h1234_5678;
    settle();
    check("w1_req", 32'(imem_req), 32'd1);
    step();
    run = 1'b0;
    for (int c = 2; c <= 3; c++) begin
      settle();
      check("w_req_held", 32'(imem_req), 32'd1);
      check("w_addr", 32'(imem_addr), 32'd0);
      check("w_instr_stable", instr, 32'd0);
      check("w_state", 32'(state), 32'd0);
      step();
    end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0800;
    settle();
    check("w4_req", 32'(imem_req), 32'd1);
    step();
    imem_ack = 1'b0;
    check("w_instr_load", instr, 32'h0000_0800);
    check("w_pc", 32'(pc), 32'd1);
    step();
    step();
    check("w_wb_state", 32'(state), 32'd3);
    check("w_wb_regwr", 32'(reg_write), 32'd1);
    step();
    step();
    check("w_idle_state", 32'(state), 32'd0);
    check("w_idle_req", 32'(imem_req), 32'd0);
    check("w_retired", 32'(retired), 32'd1);

    // 3: illegal opcode 10100
    run = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hA000_0000;
    settle();
    check("il_req", 32'(imem_req), 32'd1);
    step();
    run = 1'b0; imem_ack = 1'b0;
    check("il_decode", 32'(state), 32'd1);
    check("il_pc", 32'(pc), 32'd2);
    check("il_regwr_dec", 32'(reg_write), 32'd0);
    step();
    check("il_back_fetch", 32'(state), 32'd0);
    check("il_flag", 32'(illegal), 32'd1);
    check("il_regwr", 32'(reg_write), 32'd0);
    check("il_retired", 32'(retired), 32'd1);
    step();
    step();
    check("il_sticky", 32'(illegal), 32'd1);
    check("il_pc_hold", 32'(pc), 32'd2);

    // 4: reset during EXECUTE
    run = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0000_0800;
    step();
    imem_ack = 1'b0; run = 1'b0;
    step();
    check("rx_in_exec", 32'(state), 32'd2);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    settle();
    check("rx_state", 32'(state), 32'd0);
    check("rx_pc", 32'(pc), 32'd0);
    check("rx_regwr", 32'(reg_write), 32'd0);
    check("rx_illegal", 32'(illegal), 32'd0);
    check("rx_retired", 32'(retired), 32'd0);

    // 4b: reset during a pending fetch; the late ack must be ignored
    run = 1'b1;
    settle();
    check("rp_req", 32'(imem_req), 32'd1);
    step();
    run = 1'b0; RESET = 1'b1;
    step();
    RESET = 1'b0;
    settle();
    check("rp_req_drop", 32'(imem_req), 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0800;
    step();
    imem_ack = 1'b0;
    check("rp_late_state", 32'(state), 32'd0);
    check("rp_late_instr", instr, 32'd0);
    check("rp_late_pc", 32'(pc), 32'd0);

    // 5: halt is terminal
    run = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hF800_0000;
    step();
    imem_ack = 1'b0;
    step();
    check("h_state", 32'(state), 32'd4);
    check("h_flag", 32'(halted), 32'd1);
    for (int c = 0; c < 22; c++) begin
      imem_ack = c[0];
      settle();
      check("h_req", 32'(imem_req), 32'd0);
      check("h_regwr", 32'(reg_write), 32'd0);
      step();
    end
    imem_ack = 1'b0;
    check("h_stay", 32'(state), 32'd4);
    check("h_pc", 32'(pc), 32'd1);

    // 6: 17 back-to-back AR instructions, PC wraps 15 -> 0
    do_reset();
    run = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0000_0800;
    for (int i = 0; i < 17; i++) begin
      settle();
      check("wr_addr", 32'(imem_addr), 32'(i % 16));
      check("wr_req", 32'(imem_req), 32'd1);
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
        step();
        if (reg_write) pulses++;
      end
      check("wr_pulses", pulses, 32'd1);
      if (i == 15) check("wr_pc_wrap", 32'(pc), 32'd0);
    end
    check("wr_pc_final", 32'(pc), 32'd1);
    check("wr_retired", 32'(retired), 32'd17);
    run = 1'b0; imem_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
